// File: rtl/rr_select_scheduler.sv
// Round-robin owner select for an 8-way one-hot select bus; registered outputs, req->grant latency 1 clk.
// No backpressure: owner holds until done, request drop or MAX_HOLD expiry, then one dead GAP cycle.
module rr_select_scheduler #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant_oh,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [2:0]       last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             grant_valid_q, grant_valid_d;
    logic [2:0]       grant_idx_q, grant_idx_d;
    logic [7:0]       grant_oh_q, grant_oh_d;
    logic             timeout_q, timeout_d;

    logic [2:0] winner;
    logic [2:0] cand;
    logic       found;
    logic       owner_req;
    logic       hold_max;
    logic       exit_grant;

    // Scan starts just past the previous owner, so it ends up with lowest priority.
    always_comb begin
        winner = last_ptr_q;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            cand = last_ptr_q + 3'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_req  = req[grant_idx_q];
    assign hold_max   = (hold_cnt_q == HOLD_LIMIT);
    assign exit_grant = done || !owner_req || hold_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_ptr_q    <= 3'd7;
            hold_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= 3'd0;
            grant_oh_q    <= 8'd0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_ptr_q    <= last_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            grant_oh_q    <= grant_oh_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   if (exit_grant) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_ptr_d    = last_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_valid_d = 1'b0;
        grant_idx_d   = grant_idx_q;
        grant_oh_d    = 8'd0;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    last_ptr_d    = winner;
                    hold_cnt_d    = CNT_W'(1);
                    grant_valid_d = 1'b1;
                    grant_idx_d   = winner;
                    grant_oh_d    = 8'b1 << winner;
                end
            end
            GRANT: begin
                if (exit_grant) begin
                    hold_cnt_d = '0;
                    // done and request drop outrank budget expiry.
                    timeout_d  = hold_max && !done && owner_req;
                end else begin
                    hold_cnt_d    = hold_cnt_q + CNT_W'(1);
                    grant_valid_d = 1'b1;
                    grant_oh_d    = grant_oh_q;
                end
            end
            default: begin
                hold_cnt_d = '0;
            end
        endcase
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign grant_oh    = grant_oh_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_select_scheduler.sv
// Directed and randomized checks of rr_select_scheduler (MAX_HOLD=4 main instance, MAX_HOLD=1 second instance).
module tb_rr_select_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic       timeout;

    logic [7:0] req1;
    logic       done1;
    logic       grant_valid1;
    logic [2:0] grant_idx1;
    logic [7:0] grant_oh1;
    logic       timeout1;

    int n_checks;
    int n_fail;

    rr_select_scheduler #(.MAX_HOLD(4), .CNT_W(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .grant_oh   (grant_oh),
        .timeout    (timeout)
    );

    rr_select_scheduler #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req1),
        .done       (done1),
        .grant_valid(grant_valid1),
        .grant_idx  (grant_idx1),
        .grant_oh   (grant_oh1),
        .timeout    (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [2:0] idx);
        check_eq({tag, "_vld"}, 32'(grant_valid), 32'd1);
        check_eq({tag, "_idx"}, 32'(grant_idx), 32'(idx));
        check_eq({tag, "_oh"}, 32'(grant_oh), 32'(8'b1 << idx));
        check_eq({tag, "_to"}, 32'(timeout), 32'd0);
    endtask

    task automatic expect_idle(input string tag, input logic exp_to);
        check_eq({tag, "_vld"}, 32'(grant_valid), 32'd0);
        check_eq({tag, "_oh"}, 32'(grant_oh), 32'd0);
        check_eq({tag, "_to"}, 32'(timeout), 32'(exp_to));
    endtask

    initial begin
        logic [7:0] req_app;
        logic [7:0] flip;
        logic       prev_vld;
        logic [2:0] prev_idx;
        int         low_cnt;
        int         maxw;
        int         waitc [8];

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        req1  = 8'h00;
        done1 = 1'b0;

        // Reset state
        step();
        step();
        expect_idle("reset", 1'b0);
        check_eq("reset_idx", 32'(grant_idx), 32'd0);
        rst_n = 1'b1;

        // 1: single requester, done ends ownership
        req = 8'h01;
        step();
        expect_grant("t1_grant", 3'd0);
        done = 1'b1;
        step();
        expect_idle("t1_gap", 1'b0);
        check_eq("t1_gap_idx", 32'(grant_idx), 32'd0);
        done = 1'b0;
        req  = 8'h00;
        step();
        expect_idle("t1_idle", 1'b0);

        // 2: all requesting, done each grant cycle -> rotation from 1, 3-cycle period
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            expect_grant("t2_grant", 3'((k + 1) % 8));
            step();
            expect_idle("t2_gap", 1'b0);
            if (k == 8) req = 8'h00;
            step();
            expect_idle("t2_idle", 1'b0);
        end
        done = 1'b0;

        // 3: hold budget expiry then hand-over to the other requester
        req = 8'h24;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_grant("t3_hold", 3'd2);
        end
        step();
        expect_idle("t3_gap_timeout", 1'b1);
        check_eq("t3_gap_idx", 32'(grant_idx), 32'd2);
        step();
        expect_idle("t3_idle", 1'b0);
        step();
        expect_grant("t3_next", 3'd5);
        done = 1'b1;
        step();
        expect_idle("t3_gap2", 1'b0);
        done = 1'b0;
        req  = 8'h00;
        step();
        expect_idle("t3_idle2", 1'b0);

        // 3b: done in the last budget cycle wins over timeout
        req = 8'h24;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_grant("t3b_hold", 3'd2);
        end
        done = 1'b1;
        step();
        expect_idle("t3b_gap_no_timeout", 1'b0);
        done = 1'b0;
        req  = 8'h00;
        step();
        expect_idle("t3b_idle", 1'b0);

        // 4: owner 3 drops request in its 2nd grant cycle
        req = 8'h08;
        step();
        expect_grant("t4_grant1", 3'd3);
        step();
        expect_grant("t4_grant2", 3'd3);
        req = 8'h00;
        step();
        expect_idle("t4_gap", 1'b0);
        check_eq("t4_gap_idx", 32'(grant_idx), 32'd3);
        req = 8'h18;
        step();
        expect_idle("t4_idle", 1'b0);
        step();
        expect_grant("t4_lastptr", 3'd4);
        done = 1'b1;
        step();
        expect_idle("t4_gap2", 1'b0);
        done = 1'b0;
        req  = 8'h00;
        step();

        // 5: async reset mid-grant
        req = 8'h40;
        step();
        expect_grant("t5_grant", 3'd6);
        #3;
        rst_n = 1'b0;
        #1;
        expect_idle("t5_async_rst", 1'b0);
        check_eq("t5_async_rst_idx", 32'(grant_idx), 32'd0);
        step();
        expect_idle("t5_in_rst", 1'b0);
        req   = 8'h41;
        rst_n = 1'b1;
        step();
        expect_grant("t5_after_rst", 3'd0);
        done = 1'b1;
        step();
        expect_idle("t5_gap", 1'b0);
        done = 1'b0;
        req  = 8'h00;
        step();
        expect_idle("t5_idle", 1'b0);

        // MAX_HOLD=1: every grant is one cycle; timeout only if still requesting
        req1 = 8'h04;
        step();
        check_eq("mh1_vld", 32'(grant_valid1), 32'd1);
        check_eq("mh1_oh", 32'(grant_oh1), 32'h04);
        check_eq("mh1_to0", 32'(timeout1), 32'd0);
        step();
        check_eq("mh1_gap_vld", 32'(grant_valid1), 32'd0);
        check_eq("mh1_gap_to", 32'(timeout1), 32'd1);
        step();
        check_eq("mh1_idle_to", 32'(timeout1), 32'd0);
        check_eq("mh1_idle_vld", 32'(grant_valid1), 32'd0);
        step();
        check_eq("mh1_regrant_idx", 32'(grant_idx1), 32'd2);
        check_eq("mh1_regrant_vld", 32'(grant_valid1), 32'd1);
        req1 = 8'h00;
        step();
        check_eq("mh1_drop_to", 32'(timeout1), 32'd0);
        check_eq("mh1_drop_vld", 32'(grant_valid1), 32'd0);

        // 6: random traffic with invariant and starvation checks
        prev_vld = 1'b0;
        prev_idx = 3'd0;
        low_cnt  = 10;
        for (int i = 0; i < 8; i++) waitc[i] = 0;
        req = 8'hFF;
        for (int c = 0; c < 4000; c++) begin
            flip = 8'h00;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(7) == 0) flip[i] = 1'b1;
            req     = req ^ flip;
            done    = ($urandom_range(3) == 0);
            req_app = req;
            step();
            check_eq("rnd_oh_idx", 32'(grant_oh), grant_valid ? 32'(8'b1 << grant_idx) : 32'd0);
            if (grant_valid && !prev_vld) begin
                check_eq("rnd_gap", 32'(low_cnt >= 2), 32'd1);
                check_eq("rnd_owner_req", 32'(req_app[grant_idx]), 32'd1);
            end
            if (grant_valid && prev_vld)
                check_eq("rnd_idx_stable", 32'(grant_idx), 32'(prev_idx));
            maxw = 0;
            for (int i = 0; i < 8; i++) begin
                if (!req_app[i])
                    waitc[i] = 0;
                else if (grant_valid && !prev_vld)
                    waitc[i] = (grant_idx == 3'(i)) ? 0 : waitc[i] + 1;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            if (grant_valid && !prev_vld)
                check_eq("rnd_starve", 32'(maxw <= 7), 32'd1);
            low_cnt  = grant_valid ? 0 : ((low_cnt < 10) ? low_cnt + 1 : low_cnt);
            prev_vld = grant_valid;
            prev_idx = grant_idx;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
